// File: rtl/idct_1d_seq.sv
// 8-point 1-D inverse DCT, sequential.
// X0..X7 stream in, then one multiply-accumulate unit builds each x[n]
// over 8 cycles. x0..x7 stream out with out_last marking x7.
// Data is Q11.4. The cosine table holds 0.5*cos(m*pi/16) in Q0.15.
`timescale 1ns/1ps

module idct_1d_seq #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int ACCW = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tbl_wr_en,
  input  logic [2:0]    tbl_wr_addr,
  input  logic [CW-1:0] tbl_wr_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e                 state_q;
  logic [2:0]             k_q;
  logic [2:0]             n_q;
  logic [2:0]             j_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_d;
  logic [DW-1:0]          x_q   [8];
  logic [CW-1:0]          tbl_q [8];
  logic [DW-1:0]          out_data_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic                   in_ready_q;
  logic                   busy_q;

  logic [4:0]             m_raw;
  logic [5:0]             m_fold;
  logic [2:0]             t_idx;
  logic                   w_zero;
  logic                   w_neg;
  logic signed [CW:0]     t_ext;
  logic signed [CW:0]     w;
  logic signed [DW+CW:0]  prod;

  wire in_fire = in_valid && in_ready_q;

  // Cosine weight for the current (j, n) pair, then the MAC step.
  // NOTE: combinational logic uses blocking '=' and gives every signal a default first, so no latch can be inferred.
  always_comb begin
    w_zero = 1'b0;
    w_neg  = 1'b0;
    t_idx  = 3'd0;
    // Angle index m = (2n+1)*j mod 32, folded into 0..16 (cos is even about 0 and 2*pi).
    m_raw  = 5'({3'b000, n_q, 1'b1} * {4'b0000, j_q});
    m_fold = (m_raw > 5'd16) ? (6'd32 - {1'b0, m_raw}) : {1'b0, m_raw};
    // cos(pi/2) is zero; past pi/2 the cosine mirrors with a sign flip.
    if (m_fold == 6'd8) begin
      w_zero = 1'b1;
    end else if (m_fold > 6'd8) begin
      w_neg = 1'b1;
      t_idx = 3'(6'd16 - m_fold);
    end else begin
      t_idx = m_fold[2:0];
    end
    t_ext = $signed({tbl_q[t_idx][CW-1], tbl_q[t_idx]});
    w     = w_zero ? '0 : (w_neg ? -t_ext : t_ext);
    prod  = (DW+CW+1)'($signed(x_q[j_q])) * (DW+CW+1)'(w);
    // j == 0 starts a fresh sum for the next output sample.
    acc_d = (j_q == 3'd0) ? ACCW'(prod) : (acc_q + ACCW'(prod));
  end

  // Cosine table: writable in any state, defaults restored on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q[0] <= CW'(16'h2D41);
      tbl_q[1] <= CW'(16'h3EC5);
      tbl_q[2] <= CW'(16'h3B21);
      tbl_q[3] <= CW'(16'h3536);
      tbl_q[4] <= CW'(16'h2D41);
      tbl_q[5] <= CW'(16'h238E);
      tbl_q[6] <= CW'(16'h187D);
      tbl_q[7] <= CW'(16'h0C7C);
    end else if (tbl_wr_en) begin
      tbl_q[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  // Coefficient buffer: captures X[k] on each input handshake.
  // NOTE: this buffer has no reset; every entry is rewritten before the MAC phase reads it.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      x_q[k_q] <= in_data;
    end
  end

  // Control FSM with registered stream outputs.
  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      k_q         <= 3'd0;
      n_q         <= 3'd0;
      j_q         <= 3'd0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (in_fire) begin
            k_q <= k_q + 3'd1;
            if (k_q == 3'd7) begin
              state_q    <= S_MAC;
              n_q        <= 3'd0;
              j_q        <= 3'd0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          j_q   <= j_q + 3'd1;
          if (j_q == 3'd7) begin
            state_q     <= S_OUT;
            out_data_q  <= DW'(acc_d >>> 15);
            out_valid_q <= 1'b1;
            out_last_q  <= (n_q == 3'd7);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (n_q == 3'd7) begin
              state_q    <= S_LOAD;
              k_q        <= 3'd0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              state_q <= S_MAC;
              n_q     <= n_q + 3'd1;
              j_q     <= 3'd0;
            end
          end
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_idct_1d_seq.sv
// Scoreboard bench for idct_1d_seq: directed DC/AC/back-pressure/table/reset
// cases followed by randomized blocks, all checked against a plain-arithmetic
// inverse DCT model.
`timescale 1ns/1ps

module tb_idct_1d_seq;

  typedef logic [15:0] blk_t [8];
  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  localparam logic [15:0] T_DEF [8] = '{16'h2D41, 16'h3EC5, 16'h3B21, 16'h3536,
                                        16'h2D41, 16'h238E, 16'h187D, 16'h0C7C};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_wr_en = 1'b0;
  logic [2:0]  tbl_wr_addr = 3'd0;
  logic [15:0] tbl_wr_data = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;

  idct_1d_seq #(.DW(16), .CW(16), .ACCW(36)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tbl_wr_en   (tbl_wr_en),
    .tbl_wr_addr (tbl_wr_addr),
    .tbl_wr_data (tbl_wr_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb_q [$];
  int unsigned hs_q [$];
  logic [15:0] cap_q [$];
  int          n_out = 0;
  int unsigned last_acc = 0;
  logic [15:0] tbl_m [8];
  bit          rand_ready = 1'b0;

  blk_t dc_blk, ac_blk, rnd_blk;
  int   base;
  bit   found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Reference: x[n] = floor( sum_j X[j]*C[(2n+1)j mod 32] / 2^15 ), where
  // C[] is one full period of 0.5*cos(m*pi/16) rebuilt from the table by
  // cosine symmetry: even about 0, odd about pi/2, period 2*pi.
  function automatic void idct_ref(input blk_t x, output blk_t y);
    longint c [32];
    longint s;
    int     mm;
    for (int m = 0; m < 32; m++) begin
      mm = (m > 16) ? 32 - m : m;
      if (mm < 8)       c[m] = longint'($signed(tbl_m[mm]));
      else if (mm == 8) c[m] = 0;
      else              c[m] = -longint'($signed(tbl_m[16 - mm]));
    end
    for (int n = 0; n < 8; n++) begin
      s = 0;
      for (int j = 0; j < 8; j++) begin
        s += longint'($signed(x[j])) * c[((2 * n + 1) * j) % 32];
      end
      y[n] = 16'(s >>> 15);
    end
  endfunction

  task automatic send_block(input blk_t x, input int gap_max);
    blk_t y;
    bit   ok;
    int   g;
    idct_ref(x, y);
    for (int n = 0; n < 8; n++) sb_q.push_back('{data: y[n], last: (n == 7)});
    for (int i = 0; i < 8; i++) begin
      if (gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        if (g > 0) begin
          in_valid = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = x[i];
      ok = 1'b0;
      for (int t = 0; t < 600; t++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_timeout("in_accept");
      if (i == 7) last_acc = cyc + 1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(posedge clk);
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout("output_drain");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic tbl_write(input logic [2:0] addr, input logic [15:0] data);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = addr;
    tbl_wr_data = data;
    @(posedge clk);
    #1;
    tbl_wr_en = 1'b0;
    tbl_m[addr] = data;
  endtask

  // Hold reset with random inputs, checking the reset-state outputs each cycle.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    sb_q.delete();
    for (int i = 0; i < cycles; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_data     = 16'($urandom);
      tbl_wr_en   = 1'($urandom_range(0, 1));
      tbl_wr_addr = 3'($urandom_range(0, 7));
      tbl_wr_data = 16'($urandom);
      out_ready   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 16'h0000);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    tbl_wr_en = 1'b0;
    out_ready = 1'b1;
    tbl_m     = T_DEF;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [15:0] val);
    check({name, "_count"}, cap_q.size(), 8);
    for (int i = 0; i < cap_q.size(); i++) check(name, cap_q[i], val);
  endtask

  // Monitor: compares every presented output against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("busy_during_out", busy, 1);
      check("in_ready_during_out", in_ready, 0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", out_data);
      end else begin
        check("out_data", out_data, sb_q[0].data);
        check("out_last", out_last, sb_q[0].last);
        if (out_ready) begin
          void'(sb_q.pop_front());
          hs_q.push_back(cyc + 1);
          cap_q.push_back(out_data);
          n_out++;
        end
      end
    end
  end

  // Random downstream back-pressure when enabled.
  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dc_blk = '{16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    ac_blk = '{16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    tbl_m  = T_DEF;
    @(posedge clk);
    #1;

    // Reset with random inputs driven
    do_reset(6);

    // DC block, out_ready held high: values, last flag, spacing
    hs_q.delete();
    cap_q.delete();
    send_block(dc_blk, 0);
    in_valid = 1'b0;
    wait_drain(400);
    check_all("dc_x", 16'h005A);
    check("dc_hs_count", hs_q.size(), 8);
    if (hs_q.size() == 8) begin
      check("dc_first_latency", hs_q[0] - last_acc, 9);
      for (int i = 1; i < 8; i++) check("dc_spacing", hs_q[i] - hs_q[i-1], 9);
      check("dc_block_len", hs_q[7] - last_acc, 72);
    end

    // AC block (X1 only)
    cap_q.delete();
    send_block(ac_blk, 0);
    in_valid = 1'b0;
    wait_drain(400);
    check("ac_count", cap_q.size(), 8);
    if (cap_q.size() == 8) begin
      check("ac_x0", cap_q[0], 16'h007D);
      check("ac_x3", cap_q[3], 16'h0018);
      check("ac_x4", cap_q[4], 16'hFFE7);
      check("ac_x7", cap_q[7], 16'hFF82);
    end

    // Back-pressure: stall 5 cycles while x3 is presented
    cap_q.delete();
    base = n_out;
    send_block(dc_blk, 0);
    in_valid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      if (n_out >= base + 3) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_timeout("bp_reach_x3");
    #1;
    out_ready = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_timeout("bp_x3_valid");
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, 16'h005A);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain(400);
    check("bp_total_outputs", n_out - base, 8);
    check_all("bp_x", 16'h005A);

    // Table write of entry 0, then reset restores the default table
    tbl_write(3'd0, 16'h4000);
    cap_q.delete();
    send_block(dc_blk, 0);
    in_valid = 1'b0;
    wait_drain(400);
    check_all("tbl_x", 16'h0080);
    do_reset(2);
    cap_q.delete();
    send_block(dc_blk, 0);
    in_valid = 1'b0;
    wait_drain(400);
    check_all("tbl_rst_x", 16'h005A);

    // Reset while x2 is presented
    base = n_out;
    send_block(dc_blk, 0);
    in_valid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      if (n_out >= base + 2) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_timeout("midrst_reach_x2");
    #1;
    out_ready = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_timeout("midrst_x2_valid");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    do_reset(3);
    check("midrst_outputs_before", n_out - base, 2);
    base = n_out;
    cap_q.delete();
    send_block(dc_blk, 0);
    in_valid = 1'b0;
    wait_drain(400);
    check("midrst_outputs_after", n_out - base, 8);
    check_all("midrst_x", 16'h005A);

    // Random blocks, random table contents, random back-pressure,
    // in_valid held high across back-to-back blocks
    rand_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        tbl_write(3'($urandom_range(0, 7)), 16'($urandom_range(0, 16'h7FFF)));
      end
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < 8; i++) rnd_blk[i] = 16'($urandom);
        send_block(rnd_blk, 2);
      end
      in_valid = 1'b0;
      wait_drain(3000);
    end
    rand_ready = 1'b0;
    #3;
    out_ready = 1'b1;
    check("final_scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
